sqrt_calculator_pipe_param: RTL

Parametrised iterative integer/fixed-point square-root unit, successor to the 16-bit sqrt_calculator.
- Generalises input width, adds optional fractional result bits and signed/unsigned mode.
- Adds remainder output, busy flag and a defined start/done handshake.
- Sits as a multi-cycle arithmetic slave behind a controller that issues start and waits for done.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_step.sv | 26 ++
 rtl/sqrt_calculator_pipe_param.sv | 117 +++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the iterative square-root unit and its step cell.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int root_width(input int in_w, input int frac_w);
    return in_w / 2 + frac_w;
  endfunction

  // The partial remainder never exceeds 2*root, so one extra bit over the root suffices.
  function automatic int rem_width(input int in_w, input int frac_w);
    return root_width(in_w, frac_w) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit-by-digit square-root iteration: brings in two radicand bits, tries {root,01}.
module sqrt_step #(
  parameter int N = 8
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] root_o
);

  logic [N+2:0] shifted;
  logic [N+2:0] trial;
  logic [N+2:0] diff;
  logic         ge;

  assign shifted = {rem_i, bits_i};
  assign trial   = {1'b0, root_i, 2'b01};
  assign diff    = shifted - trial;
  assign ge      = (shifted >= trial);

  // Root MSB is always zero before the final step, so truncation loses nothing.
  assign rem_o  = (N+1)'(ge ? diff : shifted);
  assign root_o = N'({root_i, ge});

endmodule

// File: rtl/sqrt_calculator_pipe_param.sv
// Iterative integer/fixed-point square root with start/done handshake, remainder and error flag.
module sqrt_calculator_pipe_param
  import sqrt_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_W    = 0,
  parameter int SIGNED_IN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IN_W-1:0]          in,
  output logic [IN_W/2+FRAC_W-1:0] out,
  output logic [IN_W/2+FRAC_W:0]   rem,
  output logic                     error,
  output logic                     done,
  output logic                     busy
);

  localparam int RW  = IN_W + 2 * FRAC_W;
  localparam int N   = root_width(IN_W, FRAC_W);
  localparam int RMW = rem_width(IN_W, FRAC_W);
  localparam int CW  = cnt_width(N);

  state_t          state_q;
  logic [RW-1:0]   rad_q;
  logic [N-1:0]    root_q;
  logic [RMW-1:0]  prem_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic [N-1:0]    out_q;
  logic [RMW-1:0]  rem_q;
  logic            error_q;
  logic            done_q;

  logic [N-1:0]    root_d;
  logic [RMW-1:0]  prem_d;
  logic [RW-1:0]   rad_load;
  logic            neg_in;

  assign rad_load = RW'(in) << (2 * FRAC_W);
  assign neg_in   = (SIGNED_IN != 0) && in[IN_W-1];

  sqrt_step #(
    .N(N)
  ) u_step (
    .rem_i  (prem_q),
    .root_i (root_q),
    .bits_i (rad_q[RW-1 -: 2]),
    .rem_o  (prem_d),
    .root_o (root_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
      rem_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (neg_in) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              err_q   <= 1'b0;
              rad_q   <= rad_load;
              root_q  <= '0;
              prem_q  <= '0;
              cnt_q   <= CW'(N);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rad_q  <= rad_q << 2;
          root_q <= root_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          // First FIN cycle publishes the result; second one drops done and returns to IDLE.
          if (!done_q) begin
            done_q  <= 1'b1;
            out_q   <= err_q ? '0 : root_q;
            rem_q   <= err_q ? '0 : prem_q;
            error_q <= err_q;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign out   = out_q;
  assign rem   = rem_q;
  assign error = error_q;
  assign done  = done_q;

endmodule
